// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic initiator.
//   wb_state_t : initiator FSM states (IDLE, BUS, RESP)
//   WB_ADR_W / WB_DAT_W / WB_SEL_W : bus field widths
package wb_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wishbone_master_if.sv
// Wishbone classic bus bundle between one initiator and one target.
//   ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O : driven by the initiator
//   DAT_I, ACK_I, ERR_I                     : driven by the target
// Modports: master (initiator view), slave (target view).
interface wishbone_master_if;
    import wb_pkg::*;

    logic [WB_ADR_W-1:0] ADR_O;
    logic [WB_DAT_W-1:0] DAT_O;
    logic [WB_DAT_W-1:0] DAT_I;
    logic                WE_O;
    logic [WB_SEL_W-1:0] SEL_O;
    logic                STB_O;
    logic                CYC_O;
    logic                ACK_I;
    logic                ERR_I;

    modport master (
        output ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O,
        input  DAT_I, ACK_I, ERR_I
    );

    modport slave (
        input  ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O,
        output DAT_I, ACK_I, ERR_I
    );

endinterface

// File: rtl/wb_watchdog.sv
// Bus-cycle watchdog. Counts clocks while enabled and flags expiry in the
// TIMEOUT_CYC-th enabled cycle, so the owner can end the cycle on that edge.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : restart the count (takes priority over i_enable)
//   i_enable       : count this cycle
//   o_expired      : this enabled cycle is number TIMEOUT_CYC
module wb_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    // Count holds the number of enabled cycles already completed.
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LastCnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_cnt == LastCnt);

endmodule

// File: rtl/wishbone_master.sv
// Wishbone classic single-transfer initiator. One user command becomes one
// bus cycle; the result comes back as a one-cycle response pulse.
//   CLK_I, RST_I                : clock, async active-low reset
//   cmd_valid_i / cmd_ready_o   : command handshake (ready only in IDLE)
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i        : command fields, captured on acceptance
//   rsp_valid_o                 : one-cycle response strobe
//   rsp_dat_o, rsp_err_o        : response data / error, held until next response
//   wb                          : Wishbone bus (master modport)
// Build option: define WB_MASTER_TIMEOUT_EN to add a TIMEOUT_CYC-clock
// watchdog that ends a silent bus cycle with an error response.
module wishbone_master
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                CLK_I,
    input  logic                RST_I,

    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_ADR_W-1:0] cmd_adr_i,
    input  logic [WB_DAT_W-1:0] cmd_dat_i,
    input  logic [WB_SEL_W-1:0] cmd_sel_i,

    output logic                rsp_valid_o,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,

    wishbone_master_if.master   wb
);

    wb_state_t           r_state;
    logic [WB_ADR_W-1:0] r_adr;
    logic [WB_DAT_W-1:0] r_dat;
    logic                r_we;
    logic [WB_SEL_W-1:0] r_sel;
    logic                r_cyc;
    logic                r_rsp_valid;
    logic [WB_DAT_W-1:0] r_rsp_dat;
    logic                r_rsp_err;

    logic                w_accept;
    logic                w_expired;

    assign w_accept = (r_state == IDLE) && cmd_valid_i;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk     (CLK_I),
        .i_rst_n   (RST_I),
        .i_clear   (w_accept),
        .i_enable  (r_state == BUS),
        .o_expired (w_expired)
    );
`else
    // Without the watchdog a bus cycle waits for the target indefinitely.
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state     <= IDLE;
            r_adr       <= '0;
            r_dat       <= '0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        r_adr   <= cmd_adr_i;
                        r_dat   <= cmd_dat_i;
                        r_we    <= cmd_we_i;
                        r_sel   <= cmd_sel_i;
                        r_cyc   <= 1'b1;
                        r_state <= BUS;
                    end
                end
                BUS: begin
                    // ERR wins over ACK; either wins over an expiring watchdog.
                    if (wb.ERR_I || (!wb.ACK_I && w_expired)) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= RESP;
                    end else if (wb.ACK_I) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= r_we ? '0 : wb.DAT_I;
                        r_rsp_err   <= 1'b0;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = (r_state == IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;

    assign wb.ADR_O = r_adr;
    assign wb.DAT_O = r_dat;
    assign wb.WE_O  = r_we;
    assign wb.SEL_O = r_sel;
    assign wb.CYC_O = r_cyc;
    assign wb.STB_O = r_cyc;

endmodule

// File: doc/wishbone_master.md
WISHBONE_MASTER -- requirements
Module: wishbone_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, bus-cycle watchdog limit in clocks (used only when the timeout macro is defined).
REQ-002 SHALL have port CLK_I  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port RST_I  in  1  reset, asynchronous, active-low (0 = reset).
REQ-004 SHALL have user command ports:
- cmd_valid_i in 1
- cmd_ready_o out 1
- cmd_we_i in 1 (1 = write)
- cmd_adr_i in 32
- cmd_dat_i in 32
- cmd_sel_i in 4
REQ-005 SHALL have user response ports:
- rsp_valid_o out 1 (one-cycle pulse)
- rsp_dat_o out 32 (read data)
- rsp_err_o out 1 (error or timeout)
REQ-006 SHALL have Wishbone classic initiator ports:
- ADR_O out 32
- DAT_O out 32
- DAT_I in 32
- WE_O out 1
- SEL_O out 4
- STB_O out 1
- CYC_O out 1
- ACK_I in 1
- ERR_I in 1 (tie 0 for targets without ERR)

Function
REQ-007 SHALL implement states IDLE, BUS, RESP.
REQ-008 In IDLE, cmd_ready_o SHALL be 1; it SHALL be 0 in all other states.
REQ-009 A command SHALL be accepted when cmd_valid_i and cmd_ready_o are both 1 at a clock edge; the FSM then moves IDLE->BUS.
REQ-010 On acceptance, ADR_O/DAT_O/WE_O/SEL_O SHALL register cmd_* and stay stable until the bus cycle ends.
REQ-011 In BUS, CYC_O and STB_O SHALL both be 1, starting the cycle after acceptance.
REQ-012 In BUS, ACK_I=1 at an edge SHALL end the cycle: CYC_O/STB_O drop next cycle; the FSM moves to RESP; rsp_dat_o captures DAT_I for reads or becomes 0 for writes; rsp_err_o=0.
REQ-013 In BUS, ERR_I=1 SHALL end the cycle like ACK, with rsp_err_o=1 and rsp_dat_o=0.
REQ-014 ACK_I and ERR_I both 1 in the same cycle SHALL be treated as ERR.
REQ-015 In RESP, rsp_valid_o SHALL be 1 for exactly one cycle; the FSM then returns to IDLE.
REQ-016 Minimum latency from acceptance edge to rsp_valid_o SHALL be 2 cycles (zero-wait ACK); each target wait state adds 1 cycle.
REQ-017 No response backpressure; rsp_dat_o/rsp_err_o SHALL hold their values until the next response.
REQ-018 ACK_I/ERR_I while in IDLE or RESP SHALL be ignored.
REQ-019 cmd_valid_i while not ready SHALL be ignored; the command stays pending on the user side.

Reset
REQ-020 While RST_I=0, outputs SHALL asynchronously become: state IDLE, CYC_O=STB_O=WE_O=0, ADR_O=DAT_O=0, SEL_O=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, watchdog=0.
REQ-021 Reset during BUS SHALL abort the cycle immediately, with no response generated.
REQ-022 cmd_ready_o SHALL be 1 in the first cycle after reset release.

Configuration
REQ-023 Macro WB_MASTER_TIMEOUT_EN defined: the watchdog SHALL clear on entry to BUS and increment each BUS cycle; if it reaches TIMEOUT_CYC with no ACK/ERR, the cycle SHALL end as in REQ-013 (rsp_err_o=1).
REQ-024 ACK_I or ERR_I in the expiry cycle SHALL take priority over the timeout.
REQ-025 Macro undefined: no watchdog logic; BUS SHALL wait for ACK/ERR indefinitely.

Structure
REQ-026 Shared package wb_pkg SHALL hold:
- the wb_state_t enum (IDLE, BUS, RESP)
- WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4
REQ-027 The watchdog SHALL be a sub-module wb_watchdog (inputs: clear, enable; output: expired), instantiated only under WB_MASTER_TIMEOUT_EN.

Verification
REQ-028 Write adr 0x10, dat 0xDEADBEEF, sel 0xF; target ACKs 1st BUS cycle -> CYC/STB high 1 cycle, WE_O=1, rsp_valid 2 cycles after accept, rsp_err=0.
REQ-029 Read adr 0x10; target returns 0xDEADBEEF after 3 wait states -> CYC/STB high 4 cycles, rsp_dat=0xDEADBEEF, rsp_err=0.
REQ-030 ACK_I and ERR_I asserted together -> rsp_err=1, rsp_dat=0; a spurious ACK_I in IDLE -> no rsp_valid.
REQ-031 Macro on, TIMEOUT_CYC=16, target silent -> CYC/STB drop after 16 BUS cycles, rsp_err=1; ACK in cycle 16 -> rsp_err=0.
REQ-032 RST_I pulled low mid-BUS -> CYC_O/STB_O 0 without a clock edge, no rsp_valid; cmd_ready=1 after release.
REQ-033 cmd_valid held high for two back-to-back commands -> second accepted only in IDLE, after the first rsp_valid.
